hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight destination registers after decode,
// selects forwarding sources, detects load-use stalls and gates branch flushes.
module hazard_scoreboard #(
  parameter  int REG_W      = 5,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_STAGE = 1,
  parameter  int ZERO_REG   = 31,
  parameter  int CNT_W      = 16,
  localparam int FW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rn,
  input  logic             dec_use_rn,
  input  logic [REG_W-1:0] dec_rm,
  input  logic             dec_use_rm,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_reg_write,
  input  logic             dec_is_load,
  input  logic             br_taken,
  input  logic             freeze,
  output logic             stall,
  output logic             flush_if,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Entry 0 is the stage right after decode (Ex); entry DEPTH-1 is the oldest (Wb).
  logic             ent_valid [DEPTH];
  logic [REG_W-1:0] ent_rd    [DEPTH];
  logic             ent_wr    [DEPTH];
  logic             ent_ld    [DEPTH];

  logic [FW-1:0] hit_a;
  logic [FW-1:0] hit_b;
  logic          ld_a;
  logic          ld_b;
  logic          load_use;
  logic          stall_int;
  logic          flush_int;

  // Scan oldest to youngest so the youngest producer overwrites older matches.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_wr[i] && (ent_rd[i] != REG_W'(ZERO_REG))) begin
        if (ent_rd[i] == dec_rn) begin
          hit_a = FW'(i + 1);
          ld_a  = ent_ld[i] && (i < LOAD_STAGE);
        end
        if (ent_rd[i] == dec_rm) begin
          hit_b = FW'(i + 1);
          ld_b  = ent_ld[i] && (i < LOAD_STAGE);
        end
      end
    end
    if (!dec_use_rn) begin
      hit_a = '0;
      ld_a  = 1'b0;
    end
    if (!dec_use_rm) begin
      hit_b = '0;
      ld_b  = 1'b0;
    end
  end

  assign load_use  = dec_valid && (ld_a || ld_b);
  assign stall_int = load_use || freeze;
  assign flush_int = br_taken && dec_valid && !stall_int;

  // Outputs are forced quiet while reset is held, independent of the clock.
  assign stall    = !reset && stall_int;
  assign flush_if = !reset && flush_int;
  assign fwd_a    = reset ? '0 : hit_a;
  assign fwd_b    = reset ? '0 : hit_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_rd[i]    <= '0;
        ent_wr[i]    <= 1'b0;
        ent_ld[i]    <= 1'b0;
      end
    end else if (!freeze) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        ent_valid[i] <= ent_valid[i-1];
        ent_rd[i]    <= ent_rd[i-1];
        ent_wr[i]    <= ent_wr[i-1];
        ent_ld[i]    <= ent_ld[i-1];
      end
      // A load-use stall inserts a bubble; the held decode instruction retries next cycle.
      if (load_use) begin
        ent_valid[0] <= 1'b0;
        ent_rd[0]    <= '0;
        ent_wr[0]    <= 1'b0;
        ent_ld[0]    <= 1'b0;
      end else begin
        ent_valid[0] <= dec_valid;
        ent_rd[0]    <= dec_rd;
        ent_wr[0]    <= dec_reg_write;
        ent_ld[0]    <= dec_is_load;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (load_use && !freeze && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_int && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule
